// File: rtl/instr_loader_if.sv
// Byte-stream in / instruction-memory write out bundle for instr_loader.
// INSTR_LOADER_CHECKSUM_EN adds the checksum_err status line.
interface instr_loader_if #(parameter int ADDR_W = 8);
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              imem_wr_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wr_data;
    logic              busy;
    logic              load_done;
    logic              overflow;
    logic [ADDR_W:0]   word_count;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic              checksum_err;
`endif

    modport master (
        input  start, rx_data, rx_valid,
        output imem_wr_en, imem_addr, imem_wr_data, busy, load_done, overflow, word_count
`ifdef INSTR_LOADER_CHECKSUM_EN
        , output checksum_err
`endif
    );

    modport slave (
        output start, rx_data, rx_valid,
        input  imem_wr_en, imem_addr, imem_wr_data, busy, load_done, overflow, word_count
`ifdef INSTR_LOADER_CHECKSUM_EN
        , input checksum_err
`endif
    );
endinterface

// File: rtl/instr_loader.sv
// Packs UART bytes little-endian into 32-bit words and writes them to imem until HALT_WORD.
// Optional trailing XOR checksum byte: define INSTR_LOADER_CHECKSUM_EN.
module instr_loader #(
    parameter int          ADDR_W    = 8,
    parameter int          DEPTH     = 256,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input logic           clk,
    input logic           rst,
    instr_loader_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, COLLECT, WRITE, DONE
`ifdef INSTR_LOADER_CHECKSUM_EN
        , CHECK
`endif
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

    state_t            state, state_nxt;
    logic [1:0]        byte_idx;
    logic [23:0]       shreg;
    logic [31:0]       wr_data;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   word_count;
    logic              overflow;
    logic              is_halt, full, last_byte;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]        csum;
    logic              csum_err;
`endif

    assign is_halt   = (wr_data == HALT_WORD);
    assign full      = ((word_count + 1'b1) == DEPTH_W);
    assign last_byte = (state == COLLECT) && bus.rx_valid && (byte_idx == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (bus.start) state_nxt = COLLECT;
            COLLECT:    if (last_byte) state_nxt = WRITE;
            WRITE: begin
                if (is_halt) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                    // a byte arriving alongside the HALT write is already the checksum
                    state_nxt = bus.rx_valid ? DONE : CHECK;
`else
                    state_nxt = DONE;
`endif
                end else if (full) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = COLLECT;
                end
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            CHECK: if (bus.rx_valid) state_nxt = DONE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx   <= '0;
            shreg      <= '0;
            wr_data    <= '0;
            addr       <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum       <= '0;
            csum_err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: if (bus.start) begin
                    byte_idx   <= '0;
                    addr       <= '0;
                    word_count <= '0;
                    overflow   <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    csum       <= '0;
                    csum_err   <= 1'b0;
`endif
                end
                COLLECT: if (bus.rx_valid) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                    csum <= csum ^ bus.rx_data;
`endif
                    byte_idx <= byte_idx + 1'b1;
                    case (byte_idx)
                        2'd0:    shreg[7:0]   <= bus.rx_data;
                        2'd1:    shreg[15:8]  <= bus.rx_data;
                        2'd2:    shreg[23:16] <= bus.rx_data;
                        default: wr_data      <= {bus.rx_data, shreg};
                    endcase
                end
                WRITE: begin
                    addr       <= addr + 1'b1;
                    word_count <= word_count + 1'b1;
                    if (!is_halt && full) overflow <= 1'b1;
                    // keep the stream gap-free: this byte opens the next word
                    if (!is_halt && !full && bus.rx_valid) begin
                        shreg[7:0] <= bus.rx_data;
                        byte_idx   <= 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                        csum       <= csum ^ bus.rx_data;
`endif
                    end
`ifdef INSTR_LOADER_CHECKSUM_EN
                    if (is_halt && bus.rx_valid) csum_err <= (bus.rx_data != csum);
`endif
                end
`ifdef INSTR_LOADER_CHECKSUM_EN
                CHECK: if (bus.rx_valid) csum_err <= (bus.rx_data != csum);
`endif
                default: ;
            endcase
        end
    end

    assign bus.imem_wr_en   = (state == WRITE);
    assign bus.imem_addr    = addr;
    assign bus.imem_wr_data = wr_data;
    assign bus.load_done    = (state == DONE);
    assign bus.overflow     = overflow;
    assign bus.word_count   = word_count;
`ifdef INSTR_LOADER_CHECKSUM_EN
    assign bus.busy         = (state == COLLECT) || (state == WRITE) || (state == CHECK);
    assign bus.checksum_err = csum_err;
`else
    assign bus.busy         = (state == COLLECT) || (state == WRITE);
`endif
endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: a default-depth instance and a DEPTH=4 instance
// for the overflow case; imem writes are logged on the falling edge.
module tb_instr_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_loader_if #(.ADDR_W(8)) bus0();
    instr_loader_if #(.ADDR_W(8)) bus1();

    instr_loader #(.ADDR_W(8))             dut0 (.clk(clk), .rst(rst), .bus(bus0));
    instr_loader #(.ADDR_W(8), .DEPTH(4))  dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int vecs = 0;
    int errs = 0;

    logic [7:0]  wa0[$], wa1[$];
    logic [31:0] wd0[$], wd1[$];

    always @(negedge clk) begin
        if (bus0.imem_wr_en === 1'b1) begin wa0.push_back(bus0.imem_addr); wd0.push_back(bus0.imem_wr_data); end
        if (bus1.imem_wr_en === 1'b1) begin wa1.push_back(bus1.imem_addr); wd1.push_back(bus1.imem_wr_data); end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic [7:0] d);
        @(negedge clk);
        if (sel) begin bus1.rx_valid = v; bus1.rx_data = d; end
        else     begin bus0.rx_valid = v; bus0.rx_data = d; end
    endtask

    task automatic send(input bit sel, input logic [7:0] d); drive(sel, 1'b1, d); endtask
    task automatic idle(input bit sel);                      drive(sel, 1'b0, 8'h00); endtask
    task automatic wait_cyc(input int n); repeat (n) @(negedge clk); endtask

    task automatic pulse_start(input bit sel);
        @(negedge clk);
        if (sel) bus1.start = 1'b1; else bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0; bus1.start = 1'b0;
    endtask

    task automatic do_reset;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic clr_logs;
        wa0.delete(); wd0.delete(); wa1.delete(); wd1.delete();
    endtask

    task automatic send_word(input bit sel, input logic [31:0] w);
        for (int i = 0; i < 4; i++) send(sel, w[8*i +: 8]);
    endtask

    initial begin
        bus0.start = 1'b0; bus0.rx_valid = 1'b0; bus0.rx_data = 8'h00;
        bus1.start = 1'b0; bus1.rx_valid = 1'b0; bus1.rx_data = 8'h00;

        #1;
        chk("rst_wr_en",  bus0.imem_wr_en,   1'b0);
        chk("rst_addr",   bus0.imem_addr,    8'h00);
        chk("rst_data",   bus0.imem_wr_data, 32'h0);
        chk("rst_busy",   bus0.busy,         1'b0);
        chk("rst_done",   bus0.load_done,    1'b0);
        chk("rst_ovf",    bus0.overflow,     1'b0);
        chk("rst_wcount", bus0.word_count,   9'd0);
        @(negedge clk); rst = 1'b0;

        // single word, write latency
        clr_logs();
        pulse_start(0);
        send(0, 8'h01); send(0, 8'h00); send(0, 8'h08); send(0, 8'h20);
        idle(0);
        chk("w1_wr_en",   bus0.imem_wr_en,   1'b1);
        chk("w1_addr",    bus0.imem_addr,    8'h00);
        chk("w1_data",    bus0.imem_wr_data, 32'h2008_0001);
        wait_cyc(1);
        chk("w1_wr_off",  bus0.imem_wr_en,   1'b0);
        chk("w1_addr_nx", bus0.imem_addr,    8'h01);
        chk("w1_wcount",  bus0.word_count,   9'd1);
        chk("w1_busy",    bus0.busy,         1'b1);
        chk("w1_nwrites", wa0.size(),        1);
        chk("w1_hold",    bus0.imem_wr_data, 32'h2008_0001);

        // two words back-to-back (2nd starts during WRITE), then HALT
        do_reset();
        clr_logs();
        pulse_start(0);
        send_word(0, 32'h2008_0001);
        send_word(0, 32'h8C22_0004);
        idle(0);
        wait_cyc(2);
        send_word(0, 32'hFFFF_FFFF);
        idle(0);
        wait_cyc(3);
        chk("h_nwrites",  wa0.size(), 3);
        chk("h_addr0",    wa0[0], 8'd0);
        chk("h_addr1",    wa0[1], 8'd1);
        chk("h_addr2",    wa0[2], 8'd2);
        chk("h_data0",    wd0[0], 32'h2008_0001);
        chk("h_data1",    wd0[1], 32'h8C22_0004);
        chk("h_data2",    wd0[2], 32'hFFFF_FFFF);
`ifndef INSTR_LOADER_CHECKSUM_EN
        chk("h_done",     bus0.load_done,  1'b1);
        chk("h_busy",     bus0.busy,       1'b0);
`endif
        chk("h_wcount",   bus0.word_count, 9'd3);
        chk("h_ovf",      bus0.overflow,   1'b0);

        // reset mid-word discards partial bytes
        do_reset();
        clr_logs();
        pulse_start(0);
        send(0, 8'h11); send(0, 8'h22);
        idle(0);
        do_reset();
        chk("r_busy",     bus0.busy,       1'b0);
        chk("r_wcount",   bus0.word_count, 9'd0);
        pulse_start(0);
        send(0, 8'hAA); send(0, 8'hBB); send(0, 8'hCC); send(0, 8'hDD);
        idle(0);
        wait_cyc(3);
        chk("r_nwrites",  wa0.size(), 1);
        chk("r_addr",     wa0[0], 8'd0);
        chk("r_data",     wd0[0], 32'hDDCC_BBAA);
        chk("r_wcount2",  bus0.word_count, 9'd1);

        // DEPTH=4 overflow, bytes 0x01..0x10 back-to-back
        do_reset();
        clr_logs();
        pulse_start(1);
        for (int i = 1; i <= 16; i++) send(1, 8'(i));
        idle(1);
        wait_cyc(5);
        chk("o_nwrites",  wa1.size(), 4);
        chk("o_addr0",    wa1[0], 8'd0);
        chk("o_addr3",    wa1[3], 8'd3);
        chk("o_data0",    wd1[0], 32'h0403_0201);
        chk("o_data1",    wd1[1], 32'h0807_0605);
        chk("o_data2",    wd1[2], 32'h0C0B_0A09);
        chk("o_data3",    wd1[3], 32'h100F_0E0D);
        chk("o_ovf",      bus1.overflow,   1'b1);
        chk("o_done",     bus1.load_done,  1'b1);
        chk("o_busy",     bus1.busy,       1'b0);
        chk("o_wcount",   bus1.word_count, 9'd4);
        send_word(1, 32'h0506_0708);
        idle(1);
        wait_cyc(5);
        chk("o_no5th",    wa1.size(), 4);
        chk("o_ovf_hold", bus1.overflow,   1'b1);

`ifdef INSTR_LOADER_CHECKSUM_EN
        // XOR of 01,00,00,00,FF,FF,FF,FF = 01
        do_reset();
        pulse_start(0);
        send_word(0, 32'h0000_0001);
        idle(0);
        wait_cyc(2);
        send_word(0, 32'hFFFF_FFFF);
        idle(0);
        wait_cyc(3);
        chk("c_wait_busy", bus0.busy,      1'b1);
        chk("c_wait_done", bus0.load_done, 1'b0);
        send(0, 8'h01);
        idle(0);
        wait_cyc(2);
        chk("c_ok_err",   bus0.checksum_err, 1'b0);
        chk("c_ok_done",  bus0.load_done,    1'b1);
        pulse_start(0);
        send_word(0, 32'h0000_0001);
        idle(0);
        wait_cyc(2);
        send_word(0, 32'hFFFF_FFFF);
        idle(0);
        wait_cyc(3);
        send(0, 8'h00);
        idle(0);
        wait_cyc(2);
        chk("c_bad_err",  bus0.checksum_err, 1'b1);
        chk("c_bad_done", bus0.load_done,    1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
